// File: rtl/sdf_fifo_switch_if.sv
// ---------------------------------------------------------------------------
// sdf_fifo_switch_if
// Bundle of the stream and butterfly signals for one radix-2 SDF front-end
// stage.
//   slave  : the stage itself (accepts in_*, flush and butterfly results;
//            drives in_ready, bf_a/bf_b operands, out_* and busy)
//   master : the surrounding logic (upstream source, butterfly, downstream)
// Signals:
//   in_valid/in_data/in_ready : input coefficient handshake
//   flush                     : drain request, honoured at the block boundary
//   bf_a/bf_b                 : butterfly operands (earlier sample / in_data)
//   bf_sum/bf_diff            : combinational butterfly results
//   out_valid/out_data        : stage output to the downstream delay line
//   busy                      : stage holds state that has not left yet
// ---------------------------------------------------------------------------
interface sdf_fifo_switch_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] bf_a;
    logic [WIDTH-1:0] bf_b;
    logic [WIDTH-1:0] bf_sum;
    logic [WIDTH-1:0] bf_diff;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, flush, bf_sum, bf_diff,
        input  in_ready, bf_a, bf_b, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, flush, bf_sum, bf_diff,
        output in_ready, bf_a, bf_b, out_valid, out_data, busy
    );
endinterface

// File: rtl/sdf_fifo_switch.sv
// ---------------------------------------------------------------------------
// sdf_fifo_switch
// Front end of one radix-2 single-path delay-feedback stage: the 2^DEPTH_LOG
// feedback FIFO plus the commutator that pairs sample k with sample k+D.
//   Phase 0 (fill)     : incoming samples go into the FIFO; whatever the FIFO
//                        held (lower results of the previous block) goes out.
//   Phase 1 (butterfly): FIFO sample and incoming sample feed the external
//                        butterfly; the sum leaves, the difference goes back
//                        into the FIFO slot just read.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   s    : sdf_fifo_switch_if.slave (stream, butterfly and status signals)
// No arithmetic is performed here; data passes through unmodified.
// ---------------------------------------------------------------------------
module sdf_fifo_switch #(
    parameter int WIDTH     = 12,
    parameter int DEPTH_LOG = 3
) (
    input  logic               clk,
    input  logic               rst,
    sdf_fifo_switch_if.slave   s
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    // A zero-bit counter is not expressible; the single-entry case keeps a
    // one-bit counter tied to zero.
    localparam int CNT_W = (DEPTH_LOG > 0) ? DEPTH_LOG : 1;

    // ---------------- state ----------------
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             r_flush_pend;
    logic             r_flush_busy;
    logic [DEPTH-1:0] r_vld;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    // ---------------- combinational ----------------
    logic             w_in_ready;
    logic             w_adv;
    logic             w_wrap;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_phase_next;
    logic             w_bnd_next;
    logic             w_drain_done;
    logic             w_start;
    logic             w_rd_vld;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_wr_vld;
    logic [WIDTH-1:0] w_wr_data;

    generate
        if (DEPTH_LOG == 0) begin : g_cnt_single
            assign w_wrap    = 1'b1;
            assign w_cnt_inc = '0;
        end else begin : g_cnt_multi
            assign w_wrap    = (r_cnt == CNT_W'(DEPTH - 1));
            assign w_cnt_inc = r_cnt + 1'b1;
        end
    endgenerate

    // Read and write share address r_cnt; the read sees the old entry.
    assign w_rd_vld  = r_vld[r_cnt];
    assign w_rd_data = r_mem[r_cnt];

    assign w_in_ready = ~r_flush_busy;
    // While draining the stage advances on its own, feeding empty entries.
    assign w_adv      = (s.in_valid & w_in_ready) | r_flush_busy;

    // Phase 1 keeps the slot's tag and stores the lower result; phase 0 stores
    // the new sample, or an empty entry while draining.
    assign w_wr_vld  = r_phase ? w_rd_vld : ~r_flush_busy;
    assign w_wr_data = r_phase ? s.bf_diff
                               : (r_flush_busy ? '0 : s.in_data);

    // The drain runs in phase 0 and would toggle the phase on its last
    // advance; the stage instead returns to the start of a fill block.
    assign w_drain_done = r_flush_busy & w_wrap;
    assign w_cnt_next   = w_adv ? w_cnt_inc : r_cnt;
    assign w_phase_next = !w_adv        ? r_phase :
                          w_drain_done  ? 1'b0    :
                          w_wrap        ? ~r_phase : r_phase;

    // Drain starts on the edge that leaves the stage at the block boundary
    // (cnt=0, phase=0) with a flush pending: either an idle stage already
    // sitting there, or the advance that wraps into it. Arming on the edge
    // into the boundary means no input can be accepted mid-transition, and a
    // flush that arrived during a drain restarts straight away.
    assign w_bnd_next = (w_cnt_next == '0) & ~w_phase_next;
    assign w_start    = r_flush_pend & w_bnd_next
                      & (~r_flush_busy | w_drain_done);

    // ---------------- control and tag registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_phase      <= 1'b0;
            r_flush_pend <= 1'b0;
            r_flush_busy <= 1'b0;
            r_vld        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_phase      <= w_phase_next;
            r_flush_pend <= s.flush | (r_flush_pend & ~w_start);
            r_flush_busy <= w_start | (r_flush_busy & ~w_drain_done);
            if (w_adv) begin
                r_vld[r_cnt] <= w_wr_vld;
                r_out_valid  <= w_rd_vld;
                r_out_data   <= r_phase ? s.bf_sum : w_rd_data;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    // Data storage carries no reset; only the tags decide validity.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_mem[r_cnt] <= w_wr_data;
        end
    end

    // ---------------- outputs ----------------
    assign s.in_ready  = w_in_ready;
    assign s.bf_a      = w_rd_data;
    assign s.bf_b      = s.in_data;
    assign s.out_valid = r_out_valid;
    assign s.out_data  = r_out_data;
    assign s.busy      = r_phase | (|r_vld) | r_flush_pend | r_flush_busy;

endmodule

// File: tb/tb_sdf_fifo_switch.sv
// ---------------------------------------------------------------------------
// tb_sdf_fifo_switch
// Directed bench for sdf_fifo_switch: a DEPTH_LOG=2 instance (pairing,
// stall, reset, flush/drain, ignored input) and a DEPTH_LOG=0 instance.
// The butterfly attached to each instance is (a+b) mod 3329 / (a-b) mod 3329.
// ---------------------------------------------------------------------------
module tb_sdf_fifo_switch;
    localparam int WIDTH = 12;
    localparam int Q     = 3329;

    logic clk;
    logic rst;

    int n_asrt;
    int n_fail;

    sdf_fifo_switch_if #(.WIDTH(WIDTH)) if4 ();
    sdf_fifo_switch_if #(.WIDTH(WIDTH)) if1 ();

    sdf_fifo_switch #(.WIDTH(WIDTH), .DEPTH_LOG(2)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .s   (if4.slave)
    );

    sdf_fifo_switch #(.WIDTH(WIDTH), .DEPTH_LOG(0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .s   (if1.slave)
    );

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        int r;
        r = (int'(a) + int'(b)) % Q;
        return WIDTH'(r);
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        int r;
        r = (int'(a) - int'(b) + Q) % Q;
        return WIDTH'(r);
    endfunction

    assign if4.bf_sum  = mod_add(if4.bf_a, if4.bf_b);
    assign if4.bf_diff = mod_sub(if4.bf_a, if4.bf_b);
    assign if1.bf_sum  = mod_add(if1.bf_a, if1.bf_b);
    assign if1.bf_diff = mod_sub(if1.bf_a, if1.bf_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One accepted input on the depth-4 instance: operands checked before the
    // edge, the registered output checked just after it.
    task automatic push4(input logic [WIDTH-1:0] d,
                         input logic             chk_a,
                         input logic [WIDTH-1:0] exp_a,
                         input logic             exp_ov,
                         input logic [WIDTH-1:0] exp_od);
        if4.in_valid = 1'b1;
        if4.in_data  = d;
        @(negedge clk);
        chk($sformatf("in_ready@in%0d", d), 32'(if4.in_ready), 32'd1);
        chk($sformatf("bf_b@in%0d", d), 32'(if4.bf_b), 32'(d));
        if (chk_a) chk($sformatf("bf_a@in%0d", d), 32'(if4.bf_a), 32'(exp_a));
        @(posedge clk); #1;
        chk($sformatf("out_valid@in%0d", d), 32'(if4.out_valid), 32'(exp_ov));
        if (exp_ov) chk($sformatf("out_data@in%0d", d), 32'(if4.out_data), 32'(exp_od));
    endtask

    initial begin
        n_asrt = 0;
        n_fail = 0;
        rst = 1'b1;
        if4.in_valid = 1'b0; if4.in_data = '0; if4.flush = 1'b0;
        if1.in_valid = 1'b0; if1.in_data = '0; if1.flush = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(if4.out_valid), 32'd0);
        chk("rst_out_data",  32'(if4.out_data),  32'd0);
        chk("rst_in_ready",  32'(if4.in_ready),  32'd1);
        chk("rst_busy",      32'(if4.busy),      32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- reset mid-stream at cnt=2, phase=1 ----
        push4(12'd1, 1'b0, 12'd0, 1'b0, 12'd0);
        push4(12'd2, 1'b0, 12'd0, 1'b0, 12'd0);
        push4(12'd3, 1'b0, 12'd0, 1'b0, 12'd0);
        push4(12'd4, 1'b0, 12'd0, 1'b0, 12'd0);
        push4(12'd5, 1'b1, 12'd1, 1'b1, 12'd6);
        push4(12'd6, 1'b1, 12'd2, 1'b1, 12'd8);
        if4.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(if4.out_valid), 32'd0);
        chk("midrst_out_data",  32'(if4.out_data),  32'd0);
        chk("midrst_in_ready",  32'(if4.in_ready),  32'd1);
        chk("midrst_busy",      32'(if4.busy),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("postrst_out_valid%0d", i), 32'(if4.out_valid), 32'd0);
            chk($sformatf("postrst_busy%0d", i),      32'(if4.busy),      32'd0);
        end

        // ---- basic pairing, with a 3-cycle stall in phase 1 at cnt=1 ----
        push4(12'd1, 1'b0, 12'd0, 1'b0, 12'd0);
        push4(12'd2, 1'b0, 12'd0, 1'b0, 12'd0);
        push4(12'd3, 1'b0, 12'd0, 1'b0, 12'd0);
        push4(12'd4, 1'b0, 12'd0, 1'b0, 12'd0);
        push4(12'd5, 1'b1, 12'd1, 1'b1, 12'd6);
        if4.in_valid = 1'b0;
        if4.in_data  = 12'd99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall_bf_a%0d", i), 32'(if4.bf_a), 32'd2);
            chk($sformatf("stall_busy%0d", i), 32'(if4.busy), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("stall_out_valid%0d", i), 32'(if4.out_valid), 32'd0);
        end
        push4(12'd6,  1'b1, 12'd2, 1'b1, 12'd8);
        push4(12'd7,  1'b1, 12'd3, 1'b1, 12'd10);
        push4(12'd8,  1'b1, 12'd4, 1'b1, 12'd12);
        push4(12'd9,  1'b0, 12'd0, 1'b1, 12'd3325);
        push4(12'd10, 1'b0, 12'd0, 1'b1, 12'd3325);
        push4(12'd11, 1'b0, 12'd0, 1'b1, 12'd3325);
        push4(12'd12, 1'b0, 12'd0, 1'b1, 12'd3325);

        // ---- flush pulsed at cnt=2, phase=1 ----
        push4(12'd13, 1'b1, 12'd9,  1'b1, 12'd22);
        push4(12'd14, 1'b1, 12'd10, 1'b1, 12'd24);
        if4.flush = 1'b1;
        push4(12'd15, 1'b1, 12'd11, 1'b1, 12'd26);
        if4.flush = 1'b0;
        push4(12'd16, 1'b1, 12'd12, 1'b1, 12'd28);

        // ---- drain: 4 cycles, input 55 offered and ignored ----
        if4.in_valid = 1'b1;
        if4.in_data  = 12'd55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("drain_in_ready%0d", i), 32'(if4.in_ready), 32'd0);
            chk($sformatf("drain_busy%0d", i),     32'(if4.busy),     32'd1);
            @(posedge clk); #1;
            chk($sformatf("drain_out_valid%0d", i), 32'(if4.out_valid), 32'd1);
            chk($sformatf("drain_out_data%0d", i),  32'(if4.out_data),  32'd3325);
        end
        if4.in_valid = 1'b0;
        @(negedge clk);
        chk("after_drain_in_ready", 32'(if4.in_ready), 32'd1);
        chk("after_drain_busy",     32'(if4.busy),     32'd0);
        @(posedge clk); #1;
        chk("after_drain_out_valid", 32'(if4.out_valid), 32'd0);
        // Drained slots hold empty entries, not the ignored 55.
        push4(12'd100, 1'b1, 12'd0, 1'b0, 12'd0);
        if4.in_valid = 1'b0;

        // ---- DEPTH_LOG=0 ----
        if1.in_valid = 1'b1;
        if1.in_data  = 12'd7;
        @(negedge clk);
        chk("d0_bf_b_7", 32'(if1.bf_b), 32'd7);
        @(posedge clk); #1;
        chk("d0_out_valid_7", 32'(if1.out_valid), 32'd0);
        chk("d0_busy_7",      32'(if1.busy),      32'd1);
        if1.in_data = 12'd9;
        @(negedge clk);
        chk("d0_bf_a_9", 32'(if1.bf_a), 32'd7);
        @(posedge clk); #1;
        chk("d0_out_valid_9", 32'(if1.out_valid), 32'd1);
        chk("d0_out_data_9",  32'(if1.out_data),  32'd16);
        if1.in_data = 12'd20;
        @(negedge clk);
        chk("d0_bf_a_20", 32'(if1.bf_a), 32'd3327);
        @(posedge clk); #1;
        chk("d0_out_valid_20", 32'(if1.out_valid), 32'd1);
        chk("d0_out_data_20",  32'(if1.out_data),  32'd3327);
        if1.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("d0_idle_out_valid", 32'(if1.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
